timer_hex_display: RTL and testbench

TIMER_HEX_DISPLAY -- requirements
Module: timer_hex_display

---
 rtl/timer_hex_display.sv | 124 ++++++++++++
 tb/tb_timer_hex_display.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/timer_hex_display.sv
// rtl/timer_hex_display.sv - 7-bit seconds value to three 7-segment digits via double-dabble
module timer_hex_display #(
    parameter int BLANK_LEADING = 1
) (
    input  logic       Clock_50,
    input  logic       Reset,
    input  logic [6:0] bin_in,
    input  logic       bin_valid,
    input  logic       blank_en,
    output logic       busy,
    output logic       done,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;
    localparam logic       BLANK_ON  = (BLANK_LEADING != 0);
    localparam logic [6:0] RST_UPPER = BLANK_ON ? SEG_BLANK : SEG_ZERO;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    state_t      state;
    logic [6:0]  shift_reg;
    logic [11:0] bcd;
    logic [2:0]  iter;
    logic [6:0]  pat2, pat1, pat0;

    logic [11:0] bcd_adj;
    logic [11:0] bcd_next;
    logic [6:0]  new2, new1, new0;
    logic [6:0]  show2, show1, show0;

    always_comb begin
        bcd_adj = bcd;
        for (int n = 0; n < 3; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5)
                bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[10:0], shift_reg[6]};

        // Leading-zero blanking looks at the finished BCD word held during UPDATE
        new2 = (BLANK_ON && bcd[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd[11:8]);
        new1 = (BLANK_ON && bcd[11:4] == 8'd0) ? SEG_BLANK : seg7(bcd[7:4]);
        new0 = seg7(bcd[3:0]);

        show2 = (state == UPDATE) ? new2 : pat2;
        show1 = (state == UPDATE) ? new1 : pat1;
        show0 = (state == UPDATE) ? new0 : pat0;
    end

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bcd       <= '0;
            iter      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pat2      <= RST_UPPER;
            pat1      <= RST_UPPER;
            pat0      <= SEG_ZERO;
            HEX2      <= RST_UPPER;
            HEX1      <= RST_UPPER;
            HEX0      <= SEG_ZERO;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bin_valid) begin
                        shift_reg <= bin_in;
                        bcd       <= '0;
                        iter      <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd       <= bcd_next;
                    shift_reg <= {shift_reg[5:0], 1'b0};
                    iter      <= iter + 3'd1;
                    if (iter == 3'd6)
                        state <= UPDATE;
                end
                UPDATE: begin
                    pat2  <= new2;
                    pat1  <= new1;
                    pat0  <= new0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Output stage sees freshly committed digits in the same edge as done
            HEX2 <= blank_en ? SEG_BLANK : show2;
            HEX1 <= blank_en ? SEG_BLANK : show1;
            HEX0 <= blank_en ? SEG_BLANK : show0;
        end
    end

endmodule

// File: tb/tb_timer_hex_display.sv
// tb/tb_timer_hex_display.sv - randomized and directed bench with decimal-digit reference model
module tb_timer_hex_display;

    logic       Clock_50 = 1'b0;
    logic       Reset = 1'b0;
    logic [6:0] bin_in = '0;
    logic       bin_valid = 1'b0;
    logic       blank_en = 1'b0;
    logic       busy_a, done_a, busy_b, done_b;
    logic [6:0] hex2_a, hex1_a, hex0_a, hex2_b, hex1_b, hex0_b;

    int checks = 0;
    int failures = 0;

    // Reference model state: conversion age and last committed value
    bit in_reset = 1'b0;
    bit m_active = 1'b0;
    int m_age = 0;
    int m_val = 0;
    int m_shown = 0;
    bit m_done = 1'b0;
    bit m_blank = 1'b0;

    int seg_tbl [10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};

    timer_hex_display #(.BLANK_LEADING(1)) dut_a (
        .Clock_50(Clock_50), .Reset(Reset), .bin_in(bin_in), .bin_valid(bin_valid),
        .blank_en(blank_en), .busy(busy_a), .done(done_a),
        .HEX2(hex2_a), .HEX1(hex1_a), .HEX0(hex0_a)
    );

    timer_hex_display #(.BLANK_LEADING(0)) dut_b (
        .Clock_50(Clock_50), .Reset(Reset), .bin_in(bin_in), .bin_valid(bin_valid),
        .blank_en(blank_en), .busy(busy_b), .done(done_b),
        .HEX2(hex2_b), .HEX1(hex1_b), .HEX0(hex0_b)
    );

    always #10 Clock_50 = ~Clock_50;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int exp_seg(input int value, input int pos, input bit bl);
        int h, t, o;
        h = value / 100;
        t = (value / 10) % 10;
        o = value % 10;
        if (pos == 2) return (bl && h == 0) ? 'h7F : seg_tbl[h];
        if (pos == 1) return (bl && h == 0 && t == 0) ? 'h7F : seg_tbl[t];
        return seg_tbl[o];
    endfunction

    task automatic check_all(input string tag);
        int e2a, e1a, e0a, e2b, e1b, e0b;
        e2a = m_blank ? 'h7F : exp_seg(m_shown, 2, 1'b1);
        e1a = m_blank ? 'h7F : exp_seg(m_shown, 1, 1'b1);
        e0a = m_blank ? 'h7F : exp_seg(m_shown, 0, 1'b1);
        e2b = m_blank ? 'h7F : exp_seg(m_shown, 2, 1'b0);
        e1b = m_blank ? 'h7F : exp_seg(m_shown, 1, 1'b0);
        e0b = m_blank ? 'h7F : exp_seg(m_shown, 0, 1'b0);
        check({tag, ".busy"}, int'(busy_a), int'(m_active));
        check({tag, ".done"}, int'(done_a), int'(m_done));
        check({tag, ".hex2"}, int'(hex2_a), e2a);
        check({tag, ".hex1"}, int'(hex1_a), e1a);
        check({tag, ".hex0"}, int'(hex0_a), e0a);
        check({tag, ".busy_nb"}, int'(busy_b), int'(m_active));
        check({tag, ".done_nb"}, int'(done_b), int'(m_done));
        check({tag, ".hex2_nb"}, int'(hex2_b), e2b);
        check({tag, ".hex1_nb"}, int'(hex1_b), e1b);
        check({tag, ".hex0_nb"}, int'(hex0_b), e0b);
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_age = 0;
        m_shown = 0;
        m_done = 1'b0;
        m_blank = 1'b0;
    endtask

    // Drive inputs, take one rising edge, advance the model, sample 1 ns later
    task automatic step(input bit valid, input int val, input bit blank, input string tag);
        bin_valid = valid;
        bin_in = 7'(val);
        blank_en = blank;
        @(posedge Clock_50);
        if (!in_reset) begin
            m_done = 1'b0;
            if (m_active) begin
                m_age++;
                if (m_age == 8) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                    m_shown = m_val;
                end
            end else if (valid) begin
                m_active = 1'b1;
                m_age = 0;
                m_val = val;
            end
            m_blank = blank;
        end
        #1;
        check_all(tag);
    endtask

    task automatic pulse_reset_async(input string tag);
        #4;
        Reset = 1'b1;
        in_reset = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        step(1'b1, 99, 1'b1, {tag, ".held"});
        Reset = 1'b0;
        in_reset = 1'b0;
    endtask

    task automatic convert(input int val, input bit blank, input string tag);
        step(1'b1, val, blank, tag);
        for (int i = 0; i < 8; i++) step(1'b0, 0, blank, tag);
    endtask

    initial begin
        Reset = 1'b1;
        in_reset = 1'b1;
        #5;
        model_reset();
        check_all("reset");
        step(1'b0, 0, 1'b0, "reset_hold");
        Reset = 1'b0;
        in_reset = 1'b0;
        step(1'b0, 0, 1'b0, "post_reset");

        convert(100, 1'b0, "c100");
        check("c100.value", int'(hex2_a), 'h79);
        convert(7, 1'b0, "c7");
        check("c7.hex0", int'(hex0_a), 'h78);

        // 127 in flight, 5 requested mid-conversion and on the UPDATE edge
        step(1'b1, 127, 1'b0, "c127");
        step(1'b0, 0, 1'b0, "c127");
        step(1'b0, 0, 1'b0, "c127");
        step(1'b1, 5, 1'b0, "c127.ign");
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0, "c127");
        step(1'b1, 5, 1'b0, "c127.upd");
        step(1'b1, 5, 1'b0, "c5");
        for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b0, "c5");
        check("c5.hex0", int'(hex0_a), 'h12);

        // Reset aborts 42 after 59 was committed
        convert(59, 1'b0, "c59");
        step(1'b1, 42, 1'b0, "c42");
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, "c42");
        pulse_reset_async("abort");
        for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b0, "abort.idle");

        // blank_en toggling every 3 cycles around a 50 -> 49 update
        convert(50, 1'b0, "c50");
        for (int i = 0; i < 30; i++)
            step(i == 7, 49, ((i / 3) % 2) == 0, "flash");
        step(1'b0, 0, 1'b0, "flash.end");
        check("flash.hex1", int'(hex1_a), 'h19);
        check("flash.hex0", int'(hex0_a), 'h10);

        for (int v = 0; v < 128; v++) convert(v, 1'b0, "sweep");

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) pulse_reset_async("rand.rst");
            else step($urandom_range(0, 1) == 1, int'($urandom_range(0, 127)),
                      $urandom_range(0, 3) == 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
